// File: rtl/shift_rotate_sequencer.sv
// Multi-cycle shift/rotate unit: one operation per start handshake, one bit per clock.
// Supports ROR, ROL, SRL, SLL and SRA; reports the final word and the last bit shifted out.
module shift_rotate_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] amount,
    input  logic [WIDTH-1:0] value,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ROR = 3'd0,
        OP_ROL = 3'd1,
        OP_SRL = 3'd2,
        OP_SLL = 3'd3,
        OP_SRA = 3'd4
    } op_t;

    state_t             state;
    state_t             state_nx;
    op_t                op_r;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   amt;
    logic               op_legal;
    logic [WIDTH-1:0]   step_res;
    logic               step_carry;

    assign amt = amount[CNT_W-1:0];

    always_comb begin
        op_legal = (op <= 3'd4);
    end

    // Single-bit step for the latched operation.
    always_comb begin
        step_res   = result;
        step_carry = carry;
        case (op_r)
            OP_ROR: begin
                step_res   = {result[0], result[WIDTH-1:1]};
                step_carry = result[0];
            end
            OP_ROL: begin
                step_res   = {result[WIDTH-2:0], result[WIDTH-1]};
                step_carry = result[WIDTH-1];
            end
            OP_SRL: begin
                step_res   = {1'b0, result[WIDTH-1:1]};
                step_carry = result[0];
            end
            OP_SLL: begin
                step_res   = {result[WIDTH-2:0], 1'b0};
                step_carry = result[WIDTH-1];
            end
            OP_SRA: begin
                step_res   = {result[WIDTH-1], result[WIDTH-1:1]};
                step_carry = result[0];
            end
            default: begin
                step_res   = result;
                step_carry = carry;
            end
        endcase
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    // Illegal ops behave as a zero-count pass-through.
                    if ((amt != '0) && op_legal)
                        state_nx = S_SHIFT;
                    else
                        state_nx = S_DONE;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (count == CNT_W'(1))
                    state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
            carry  <= 1'b0;
            count  <= '0;
            op_r   <= OP_ROR;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        result <= value;
                        op_r   <= op_t'(op);
                        count  <= amt;
                        carry  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    result <= step_res;
                    carry  <= step_carry;
                    count  <= count - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_rotate_sequencer.sv
// Directed bench for shift_rotate_sequencer: vector table of single operations plus
// hand-written sequences for start-while-busy and asynchronous abort.
module tb_shift_rotate_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [15:0] amount;
    logic [15:0] value;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;

    int errors = 0;
    int checks = 0;

    shift_rotate_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .amount (amount),
        .value  (value),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [15:0] amount;
        logic [15:0] value;
        logic [15:0] exp_res;
        logic        exp_carry;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Launch one op, wait (bounded) for done, then check latency, busy length, outputs.
    task automatic run_op(input string nm, input logic [2:0] o, input logic [15:0] a,
                          input logic [15:0] v, input logic [15:0] er, input logic ec,
                          input int el);
        int lat;
        int busy_n;
        @(negedge clk);
        check({nm, " ready"}, 32'(ready), 32'd1);
        start  = 1'b1;
        op     = o;
        amount = a;
        value  = v;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op     = 3'($urandom);
        amount = 16'($urandom);
        value  = 16'($urandom);
        lat    = 0;
        busy_n = 0;
        @(negedge clk);
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        check({nm, " latency"}, 32'(lat), 32'(el));
        check({nm, " busy"}, 32'(busy_n), 32'(el));
        check({nm, " result"}, 32'(result), 32'(er));
        check({nm, " carry"}, 32'(carry), 32'(ec));
        @(negedge clk);
        check({nm, " done_1cyc"}, 32'(done), 32'd0);
        check({nm, " ready_after"}, 32'(ready), 32'd1);
        check({nm, " result_hold"}, 32'(result), 32'(er));
    endtask

    initial begin
        int lat;
        int seen_done;

        vecs[0]  = '{"ror_8001_1",   3'b000, 16'd1,     16'h8001, 16'hC000, 1'b1, 1};
        vecs[1]  = '{"rol_1234_4",   3'b001, 16'd4,     16'h1234, 16'h2341, 1'b1, 4};
        vecs[2]  = '{"sra_8000_15",  3'b100, 16'd15,    16'h8000, 16'hFFFF, 1'b0, 15};
        vecs[3]  = '{"sll_abcd_n0",  3'b011, 16'h0010,  16'hABCD, 16'hABCD, 1'b0, 0};
        vecs[4]  = '{"ill_abcd",     3'b111, 16'h0010,  16'hABCD, 16'hABCD, 1'b0, 0};
        vecs[5]  = '{"ill_nz_cnt",   3'b101, 16'd5,     16'h1357, 16'h1357, 1'b0, 0};
        vecs[6]  = '{"ror_1234_4",   3'b000, 16'd4,     16'h1234, 16'h4123, 1'b0, 4};
        vecs[7]  = '{"sll_c000_2",   3'b011, 16'd2,     16'hC000, 16'h0000, 1'b1, 2};
        vecs[8]  = '{"srl_0003_2",   3'b010, 16'd2,     16'h0003, 16'h0000, 1'b1, 2};
        vecs[9]  = '{"rol_8000_x11", 3'b001, 16'h0011,  16'h8000, 16'h0001, 1'b1, 1};
        vecs[10] = '{"sra_4000_3",   3'b100, 16'hFFF3,  16'h4001, 16'h0800, 1'b0, 3};

        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'b000;
        amount = '0;
        value  = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst ready", 32'(ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst carry", 32'(carry), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].amount, vecs[i].value,
                   vecs[i].exp_res, vecs[i].exp_carry, vecs[i].exp_lat);

        // Start pulse while busy must be ignored.
        @(negedge clk);
        start  = 1'b1;
        op     = 3'b010;
        amount = 16'd8;
        value  = 16'h00FF;
        @(negedge clk);
        start  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start  = 1'b1;
        op     = 3'b011;
        amount = 16'd3;
        value  = 16'hFFFF;
        @(negedge clk);
        start  = 1'b0;
        lat = 3;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("srl_busy latency", 32'(lat), 32'd8);
        check("srl_busy result", 32'(result), 32'h0000);
        check("srl_busy carry", 32'(carry), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("srl_busy hold result", 32'(result), 32'h0000);
            check("srl_busy hold carry", 32'(carry), 32'd1);
            check("srl_busy idle", 32'(ready), 32'd1);
        end

        // Asynchronous abort mid-operation.
        @(negedge clk);
        start  = 1'b1;
        op     = 3'b001;
        amount = 16'd12;
        value  = 16'h00F0;
        @(negedge clk);
        start  = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        check("abort busy_before", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("abort ready", 32'(ready), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort result", 32'(result), 32'd0);
        check("abort carry", 32'(carry), 32'd0);
        seen_done = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("abort no_done", 32'(seen_done), 32'd0);
        run_op("rol_00f0_12", 3'b001, 16'd12, 16'h00F0, 16'h000F, 1'b1, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
